// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
//
// Handshake semantics: the requester raises start together with dividend and
// divisor; the request is taken on a rising clk edge only while busy=0. While
// busy=1 start and the operands are ignored. done is a one-cycle pulse marking
// the cycle in which quotient/remainder/div_by_zero first hold the new result;
// those outputs then stay stable until the next accepted start completes.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester side.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction and one
// quotient bit (MSB first) per clock, WIDTH iterations per division.
// Divide-by-zero completes in a single cycle with q=all ones, r=dividend.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_divider_if.slave        bus,
  output logic [1:0]          o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;        // shifting dividend / growing quotient
  logic [WIDTH-1:0] r_r;        // partial remainder, always < divisor
  logic [WIDTH-1:0] r_b;        // latched divisor
  logic [CW-1:0]    r_cnt;      // iterations left
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;

  // One restoring step: subtract by adding the inverted divisor with carry-in 1.
  // A clear top bit of the WIDTH+1-bit difference means the trial fit.
  always_comb begin
    w_shift  = {r_r, r_q[WIDTH-1]};
    w_diff   = w_shift + {1'b1, ~r_b} + (WIDTH+1)'(1);
    w_ge     = ~w_diff[WIDTH];
    w_r_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_q_next = {r_q[WIDTH-2:0], w_ge};
  end

  // Control FSM and datapath registers; results only change when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            if (bus.divisor == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_rem   <= bus.dividend;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_q     <= bus.dividend;
              r_b     <= bus.divisor;
              r_r     <= '0;
              r_cnt   <= CW'(WIDTH);
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_q_next;
            r_rem   <= w_r_next;
            r_dbz   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (WIDTH=8): directed table, mid-run and reset corner
// sequences, then random operand pairs checked against a / and % model.
module tb_seq_divider;

  localparam int W   = 8;
  localparam int LIM = 3 * W;
  localparam int RW  = 2 * W + 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  seq_divider_if #(.WIDTH(W)) u_if ();

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (u_if),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int dones_seen = 0;
  logic [RW-1:0] last_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pop and compare one expected result on every done pulse.
  always @(negedge clk) begin
    if (rst_n && u_if.done) begin
      dones_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pulse (t=%0t)", $time);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        check("result", {u_if.quotient, u_if.remainder, u_if.div_by_zero}, e);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input logic poke, input logic gap);
    int n;
    @(negedge clk);
    u_if.start    = 1'b1;
    u_if.dividend = a;
    u_if.divisor  = b;
    exp_q.push_back({eq, er, edbz});
    @(posedge clk); #1;
    u_if.start    = 1'b0;
    u_if.dividend = W'($urandom);
    u_if.divisor  = W'($urandom);
    check("busy_after_start", u_if.busy, (b != 0));
    if (b != 0)
      check("held_before_done", {u_if.quotient, u_if.remainder, u_if.div_by_zero}, last_res);
    n = 0;
    while (!u_if.done && n < LIM) begin
      @(negedge clk);
      u_if.start = 1'b0;
      if (poke && n == 3) begin
        u_if.start    = 1'b1;
        u_if.dividend = 9;
        u_if.divisor  = 3;
      end
      @(posedge clk); #1;
      n++;
      if (!u_if.done) check("busy_in_run", u_if.busy, 1);
    end
    check("latency", n, (b == 0) ? 0 : W);
    if (!u_if.done) exp_q.delete();
    check("busy_in_done", u_if.busy, 0);
    last_res = {eq, er, edbz};
    if (gap) begin
      @(posedge clk); #1;
      check("done_one_cycle", u_if.done, 0);
      check("held_after_done", {u_if.quotient, u_if.remainder, u_if.div_by_zero}, last_res);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         poke;
    logic         gap;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int d0;
    logic [W-1:0] ra, rb, rq, rr;

    vecs[0] = '{100,   7,  14,   2, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{255,   1, 255,   0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{  5,   9,   0,   5, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{255, 255,   1,   0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{ 37,   0, 255,  37, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{200,   6,  33,   2, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{ 50,   5,  10,   0, 1'b0, 1'b0, 1'b0};  // started in DONE cycle
    vecs[7] = '{  0,  13,   0,   0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{ 17,   0, 255,  17, 1'b1, 1'b0, 1'b0};

    // reset
    rst_n         = 1'b0;
    u_if.start    = 1'b0;
    u_if.dividend = '0;
    u_if.divisor  = '0;
    last_res      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",  u_if.busy, 0);
    check("reset_done",  u_if.done, 0);
    check("reset_res",   {u_if.quotient, u_if.remainder, u_if.div_by_zero}, 0);
    check("reset_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz,
             vecs[i].poke, vecs[i].gap);
    // divide by zero immediately followed by a normal op from DONE
    run_op(40, 3, 13, 1, 1'b0, 1'b0, 1'b1);

    // reset in the middle of a run: no done, outputs cleared at once
    @(negedge clk);
    u_if.start    = 1'b1;
    u_if.dividend = 100;
    u_if.divisor  = 7;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    d0    = dones_seen;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  u_if.busy, 0);
    check("midrst_done",  u_if.done, 0);
    check("midrst_res",   {u_if.quotient, u_if.remainder, u_if.div_by_zero}, 0);
    check("midrst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * W) @(posedge clk);
    #1;
    check("no_done_after_reset", dones_seen, d0);
    last_res = '0;
    run_op(100, 7, 14, 2, 1'b0, 1'b0, 1'b1);

    // random pairs against the reference model
    for (int i = 0; i < 1500; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255));
      if (rb == 0) begin
        rq = '1;
        rr = ra;
      end else begin
        rq = ra / rb;
        rr = ra % rb;
      end
      run_op(ra, rb, rq, rr, (rb == 0), 1'b0, ($urandom_range(0, 1) == 1));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
